// File: rtl/c64_mem_pkg.sv
// Shared types and address map for the C64 memory/bank controller.
// Region windows are aligned power-of-two blocks, so a window hit is a masked compare.
package c64_mem_pkg;

  typedef enum logic [2:0] {
    RGN_RAM     = 3'd0,
    RGN_BASIC   = 3'd1,
    RGN_KERNAL  = 3'd2,
    RGN_CHAR    = 3'd3,
    RGN_IO      = 3'd4,
    RGN_PORTREG = 3'd5
  } region_t;

  localparam logic [15:0] BASIC_BASE   = 16'hA000;
  localparam logic [15:0] BASIC_LIMIT  = 16'hBFFF;
  localparam logic [15:0] IO_BASE      = 16'hD000;
  localparam logic [15:0] IO_LIMIT     = 16'hDFFF;
  localparam logic [15:0] KERNAL_BASE  = 16'hE000;
  localparam logic [15:0] KERNAL_LIMIT = 16'hFFFF;

  localparam logic [15:0] PORT_DDR_ADDR  = 16'h0000;
  localparam logic [15:0] PORT_DATA_ADDR = 16'h0001;

  localparam int CFG_LORAM  = 0;
  localparam int CFG_HIRAM  = 1;
  localparam int CFG_CHAREN = 2;

  // base^limit gives the in-window offset bits of an aligned window
  function automatic logic in_window(input logic [15:0] ab,
                                     input logic [15:0] base,
                                     input logic [15:0] limit);
    return (ab & ~(base ^ limit)) == base;
  endfunction

endpackage

// File: rtl/c64_bank_decode.sv
// Combinational C64 address decoder: CPU address plus effective bank bits to target region.
// Read/write distinctions (ROM write-through, port reads) are resolved by the caller.
module c64_bank_decode
  import c64_mem_pkg::*;
(
  input  logic [15:0] cpu_ab,
  input  logic [2:0]  bank_cfg,
  output region_t     region
);

  logic w_loram;
  logic w_hiram;
  logic w_charen;

  assign w_loram  = bank_cfg[CFG_LORAM];
  assign w_hiram  = bank_cfg[CFG_HIRAM];
  assign w_charen = bank_cfg[CFG_CHAREN];

  always_comb begin
    region = RGN_RAM;
    if (cpu_ab == PORT_DDR_ADDR || cpu_ab == PORT_DATA_ADDR) begin
      region = RGN_PORTREG;
    end else if (in_window(cpu_ab, BASIC_BASE, BASIC_LIMIT)) begin
      if (w_loram && w_hiram) region = RGN_BASIC;
    end else if (in_window(cpu_ab, KERNAL_BASE, KERNAL_LIMIT)) begin
      if (w_hiram) region = RGN_KERNAL;
    end else if (in_window(cpu_ab, IO_BASE, IO_LIMIT)) begin
      // with both LORAM and HIRAM low the whole $D000 page is plain RAM
      if (w_loram || w_hiram) region = w_charen ? RGN_IO : RGN_CHAR;
    end
  end

endmodule

// File: rtl/c64_mem_ctrl.sv
// C64 memory/bank controller between the 6502 core bus and RAM/ROM/I/O,
// with the 6510 on-chip port and an optional post-reset RAM clear.
module c64_mem_ctrl
  import c64_mem_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int CLEAR_DEPTH    = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  rom_rdata,
  output logic        basic_cs,
  output logic        kernal_cs,
  output logic        char_cs,
  output logic        io_cs,
  output logic        io_we,
  input  logic [7:0]  io_rdata,
  output logic [2:0]  bank_cfg
);

  localparam logic [0:0]  ST_CLEAR   = 1'b0;
  localparam logic [0:0]  ST_RUN     = 1'b1;
  localparam logic [16:0] CLEAR_LAST = 17'(CLEAR_DEPTH - 1);

  logic [0:0]  r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_ddr;
  logic [7:0]  r_port;
  logic [7:0]  r_port_rd;
  region_t     r_sel_q;

  logic [7:0]  w_eff;
  logic [2:0]  w_cfg;
  logic        w_run;
  logic        w_clear;
  logic        w_in_clear;
  region_t     w_dec;
  region_t     w_acc;

  // undriven port pins read back as 1 through the pull-ups
  assign w_eff = (r_port & r_ddr) | ~r_ddr;
  assign w_cfg = w_eff[2:0];

  // reset gates the strobes directly so they drop the moment reset is asserted
  assign w_in_clear = (r_state == ST_CLEAR);
  assign w_run      = reset && (r_state == ST_RUN);
  assign w_clear    = reset && w_in_clear;

  c64_bank_decode u_decode (
    .cpu_ab   (cpu_ab),
    .bank_cfg (w_cfg),
    .region   (w_dec)
  );

  // writes land in RAM underneath everything except the I/O window
  always_comb begin
    w_acc = w_dec;
    if (cpu_we && w_dec != RGN_IO) w_acc = RGN_RAM;
  end

  assign cpu_rdy   = w_run;
  assign bank_cfg  = w_cfg;
  assign ram_addr  = w_in_clear ? r_cnt : cpu_ab;
  assign ram_wdata = w_in_clear ? 8'h00 : cpu_do;
  assign ram_we    = w_clear || (w_run && cpu_we && w_acc == RGN_RAM);
  assign io_we     = w_run && cpu_we && w_acc == RGN_IO;
  assign basic_cs  = w_run && (w_acc == RGN_BASIC);
  assign kernal_cs = w_run && (w_acc == RGN_KERNAL);
  assign char_cs   = w_run && (w_acc == RGN_CHAR);
  assign io_cs     = w_run && (w_acc == RGN_IO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_cnt     <= '0;
      r_ddr     <= 8'h00;
      r_port    <= 8'h00;
      r_port_rd <= 8'h00;
      r_sel_q   <= RGN_RAM;
    end else if (r_state == ST_CLEAR) begin
      r_cnt   <= r_cnt + 16'd1;
      r_sel_q <= RGN_RAM;
      if ({1'b0, r_cnt} == CLEAR_LAST) r_state <= ST_RUN;
    end else begin
      r_sel_q <= w_acc;
      if (cpu_we && cpu_ab == PORT_DDR_ADDR)  r_ddr  <= cpu_do;
      if (cpu_we && cpu_ab == PORT_DATA_ADDR) r_port <= cpu_do;
      // port reads are answered from a snapshot taken with the address
      if (w_acc == RGN_PORTREG) begin
        r_port_rd <= (cpu_ab == PORT_DDR_ADDR) ? r_ddr : w_eff;
      end
    end
  end

  always_comb begin
    cpu_di = 8'h00;
    if (w_run) begin
      case (r_sel_q)
        RGN_RAM:                         cpu_di = ram_rdata;
        RGN_BASIC, RGN_KERNAL, RGN_CHAR: cpu_di = rom_rdata;
        RGN_IO:                          cpu_di = io_rdata;
        RGN_PORTREG:                     cpu_di = r_port_rd;
        default:                         cpu_di = 8'h00;
      endcase
    end
  end

endmodule

// File: doc/c64_mem_ctrl.md
Name: c64_mem_ctrl

Overview:
Memory/bank controller directly downstream of the 6502 core bus (ab, do, we in; di out). It decodes each CPU access onto RAM, BASIC/KERNAL/CHAR ROM or the I/O window per C64 banking rules. It implements the 6510 on-chip port (DDR at $0000, data at $0001) and returns read data one cycle after the address, matching the registered-address RAM behaviour. An optional post-reset RAM clear holds the CPU off via cpu_rdy.

Parameters:
CLEAR_ON_RESET, 1, 1 = run the RAM clear sequence after reset; 0 = enter RUN immediately
CLEAR_DEPTH, 65536, number of RAM locations cleared (addresses 0..CLEAR_DEPTH-1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-low reset
cpu_ab  in  16  CPU address
cpu_do  in  8  CPU write data
cpu_we  in  1  CPU write enable
cpu_di  out  8  CPU read data, valid the cycle after the address
cpu_rdy  out  1  high when the CPU may run; low during clear
ram_addr  out  16  RAM address (RAM registers it internally)
ram_wdata  out  8  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  8  RAM read data for the previous cycle's address
rom_rdata  in  8  shared ROM read data, previous-cycle address
basic_cs  out  1  access targets BASIC ROM
kernal_cs  out  1  access targets KERNAL ROM
char_cs  out  1  access targets CHAR ROM
io_cs  out  1  access targets I/O window $D000-$DFFF
io_we  out  1  write into I/O window
io_rdata  in  8  I/O read data, previous-cycle address
bank_cfg  out  3  effective {CHAREN,HIRAM,LORAM}

Behaviour:
- Reset (reset=0, async): ddr=00, port=00, sel_q=RAM, cpu_di=00, cpu_rdy=0, ram_we=0, io_we=0, all cs=0, clear counter=0. State becomes CLEAR if CLEAR_ON_RESET=1, else RUN.
- Effective port value is eff = (port & ddr) | ~ddr, i.e. input bits read as 1 via pull-ups. bank_cfg = eff[2:0], so after reset it is 3'b111.
- CLEAR state:
  - ram_addr = counter, ram_wdata = 00, ram_we = 1, cpu_rdy = 0; CPU inputs are ignored.
  - The counter increments every cycle. After the cycle with counter = CLEAR_DEPTH-1, go to RUN.
  - cpu_rdy rises on the first RUN cycle. Clear therefore takes exactly CLEAR_DEPTH cycles.
- RUN state, combinational decode of cpu_ab using the current bank_cfg:
  - $A000-$BFFF: BASIC if LORAM & HIRAM, else RAM.
  - $E000-$FFFF: KERNAL if HIRAM, else RAM.
  - $D000-$DFFF: if LORAM | HIRAM, then I/O when CHAREN=1 and CHAR when CHAREN=0; otherwise RAM.
  - $0000/$0001: PORTREG for reads; other addresses RAM.
- Writes: ram_we = cpu_we, except when the target is I/O. In that case io_we = 1 and ram_we = 0.
  - Writes to ROM regions fall through to RAM underneath.
  - Writes to $0000 or $0001 update ddr or port at the clock edge and also write through to RAM.
- cs outputs are combinational for the current access and are 0 on writes to ROM regions.
- Read path:
  - At each edge, sel_q registers the decoded region.
  - For PORTREG, the read value is captured at the same edge: ddr for $0000, eff for $0001.
  - cpu_di muxes by sel_q: RAM→ram_rdata, ROMs→rom_rdata, IO→io_rdata, PORTREG→captured value.
  - Latency is 1 cycle. cpu_di is held until the next edge.
- A bank change written at edge N affects the decode of the access presented in cycle N+1. The read returned after edge N uses the region decoded before the write.
- ram_addr = cpu_ab in RUN.
- Reset asserted mid-clear aborts the sequence. The counter restarts at 0 on release.

Decomposition:
- Package c64_mem_pkg holds:
  - region enum {RAM, BASIC, KERNAL, CHAR, IO, PORTREG};
  - region base/limit constants;
  - port address constants $0000/$0001;
  - bank_cfg bit indices LORAM=0, HIRAM=1, CHAREN=2.
- Sub-module c64_bank_decode: purely combinational, (cpu_ab, bank_cfg) → region.
- The top level holds the clear FSM, port registers, sel_q and the data mux.

Test Plan:
- CLEAR_DEPTH=16, release reset → ram_we=1 with ram_addr 0..15 and ram_wdata 00 for 16 cycles; cpu_rdy=1 on cycle 17, ram_we follows cpu_we thereafter.
- After clear, read $A000 with rom_rdata=94 → basic_cs=1 that cycle, cpu_di=94 next cycle. Read $E000 → kernal_cs=1.
- Write $0000=07, then $0001=05 → bank_cfg=101. Read $A000 → RAM data. Read $D020 → io_cs=1. Read $0001 → cpu_di=FD. Read $0000 → 07.
- Write $0001=01 (ddr 07) → bank_cfg=001. Read $D000 with rom_rdata=3C → char_cs=1, cpu_di=3C. Write $D000=AA → ram_we=1, io_we=0.
- With bank_cfg=111, write $D020=0E → io_we=1, io_cs=1, ram_we=0. Write $E000=55 → ram_we=1, kernal_cs=0.
- CLEAR_DEPTH=16, pull reset low at counter=5 with ddr previously 07 → outputs return to reset values immediately. After release, clear restarts at ram_addr 0 and bank_cfg=111.
